// File: rtl/timing_mon_pkg.sv
// Shared types and constants for the timing pulse monitor: FSM states,
// frame type codes and measurement field widths.
package timing_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } mon_state_t;

    localparam logic [1:0] FRAME_A  = 2'b01;
    localparam logic [1:0] FRAME_B  = 2'b10;
    localparam logic [1:0] FRAME_BG = 2'b00;

    localparam int CNT_W = 32;
    localparam int IDX_W = 16;

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronizer for the looped-back pulse followed by a registered edge
// detector; rise/fall appear SYNC_STAGES+1 cycles after the input edge.
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // level is the delayed copy so it lines up with the rise/fall strobes
    assign level    = level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            level_d <= sync_out;
            rise    <= sync_out & ~level_d;
            fall    <= ~sync_out & level_d;
        end
    end

endmodule

// File: rtl/timing_pulse_monitor.sv
// Measures period and high width of a looped-back timing pulse, tags each
// pulse with frame type and index, and emits one record per pulse.
module timing_pulse_monitor
    import timing_mon_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic             frame_ext_trig,
    input  logic [1:0]       frame_type,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_width,
    output logic [1:0]       meas_frame_type,
    output logic [IDX_W-1:0] meas_pulse_idx,
    output logic [15:0]      drop_cnt,
    output logic             timeout,
    input  logic             clr_status
);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] sat_inc_idx(input logic [IDX_W-1:0] v);
        return (&v) ? v : v + IDX_W'(1);
    endfunction

    logic rise_s, fall_s, level_s;

    pulse_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .level   (level_s),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    mon_state_t       state, state_nxt;
    logic [CNT_W-1:0] period_cnt, width_cnt;
    logic             emit, load_cnt, timeout_hit, to_reached;

    logic             frame_trig_d, frame_rise;
    logic [1:0]       frame_type_lat;
    logic [IDX_W-1:0] next_idx;
    logic [1:0]       pulse_type;
    logic [IDX_W-1:0] pulse_idx;
    logic             can_write;

    assign to_reached = (period_cnt >= TIMEOUT_CYCLES);
    assign frame_rise = frame_ext_trig & ~frame_trig_d;
    assign can_write  = ~meas_valid | meas_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        emit        = 1'b0;
        load_cnt    = 1'b0;
        timeout_hit = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_s) begin
                        load_cnt  = 1'b1;
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (to_reached) begin
                        timeout_hit = 1'b1;
                        state_nxt   = IDLE;
                    end else if (fall_s) begin
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    // a rise on the timeout cycle still completes the pulse
                    if (rise_s) begin
                        emit      = 1'b1;
                        load_cnt  = 1'b1;
                        state_nxt = HIGH;
                    end else if (to_reached) begin
                        timeout_hit = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
            width_cnt  <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (load_cnt) begin
                period_cnt <= CNT_W'(1);
                width_cnt  <= CNT_W'(1);
            end else begin
                if (state == HIGH || state == LOW)
                    period_cnt <= sat_inc_cnt(period_cnt);
                if (state == HIGH && level_s)
                    width_cnt <= sat_inc_cnt(width_cnt);
            end
        end
    end

    // Tag tracking: a frame edge coinciding with a rise applies to the new pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_trig_d   <= 1'b0;
            frame_type_lat <= FRAME_BG;
            next_idx       <= '0;
            pulse_type     <= FRAME_BG;
            pulse_idx      <= '0;
        end else begin
            frame_trig_d <= frame_ext_trig;
            if (enable) begin
                if (frame_rise)
                    frame_type_lat <= frame_type;
                if (rise_s) begin
                    pulse_type <= frame_rise ? frame_type : frame_type_lat;
                    pulse_idx  <= frame_rise ? '0 : next_idx;
                end
                if (frame_rise)
                    next_idx <= rise_s ? IDX_W'(1) : '0;
                else if (rise_s)
                    next_idx <= sat_inc_idx(next_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid      <= 1'b0;
            meas_period     <= '0;
            meas_width      <= '0;
            meas_frame_type <= FRAME_BG;
            meas_pulse_idx  <= '0;
            drop_cnt        <= '0;
        end else begin
            if (emit && can_write) begin
                meas_valid      <= 1'b1;
                meas_period     <= period_cnt;
                meas_width      <= width_cnt;
                meas_frame_type <= pulse_type;
                meas_pulse_idx  <= pulse_idx;
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            if (clr_status)
                drop_cnt <= '0;
            else if (emit && !can_write && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_timing_pulse_monitor.sv
// Directed testbench for timing_pulse_monitor with hand-computed expectations.
module tb_timing_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pulse_in;
    logic        frame_ext_trig;
    logic [1:0]  frame_type;
    logic        meas_valid;
    logic        meas_ready;
    logic [31:0] meas_period;
    logic [31:0] meas_width;
    logic [1:0]  meas_frame_type;
    logic [15:0] meas_pulse_idx;
    logic [15:0] drop_cnt;
    logic        timeout;
    logic        clr_status;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] width;
        logic [1:0]  ftype;
        logic [15:0] idx;
    } rec_t;

    rec_t recs[$];

    timing_pulse_monitor #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(32'd1000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pulse_in       (pulse_in),
        .frame_ext_trig (frame_ext_trig),
        .frame_type     (frame_type),
        .meas_valid     (meas_valid),
        .meas_ready     (meas_ready),
        .meas_period    (meas_period),
        .meas_width     (meas_width),
        .meas_frame_type(meas_frame_type),
        .meas_pulse_idx (meas_pulse_idx),
        .drop_cnt       (drop_cnt),
        .timeout        (timeout),
        .clr_status     (clr_status)
    );

    always #5 clk = ~clk;

    // Accepted records are collected at the clock edge
    always @(posedge clk) begin
        if (!rst && meas_valid && meas_ready)
            recs.push_back({meas_period, meas_width, meas_frame_type, meas_pulse_idx});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        enable         = 1'b1;
        pulse_in       = 1'b0;
        frame_ext_trig = 1'b0;
        frame_type     = 2'b00;
        meas_ready     = 1'b1;
        clr_status     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        recs.delete();
    endtask

    task automatic gen_pulse(input int period, input int high, input int trig_offs);
        for (int t = 0; t < period; t++) begin
            pulse_in       = (t < high);
            frame_ext_trig = (t == trig_offs);
            tick();
        end
        frame_ext_trig = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        rst = 1'b1;
        tick();
        checks++;
        if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", meas_valid); end
        checks++;
        if (meas_period !== 32'd0 || meas_width !== 32'd0) begin
            errors++; $display("FAIL reset_data got period %0d width %0d want 0 0", meas_period, meas_width);
        end
        checks++;
        if (meas_frame_type !== 2'b00 || meas_pulse_idx !== 16'd0) begin
            errors++; $display("FAIL reset_tag got type %0d idx %0d want 0 0", meas_frame_type, meas_pulse_idx);
        end
        checks++;
        if (drop_cnt !== 16'd0 || timeout !== 1'b0) begin
            errors++; $display("FAIL reset_status got drop %0d timeout %0b want 0 0", drop_cnt, timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        rec_t r;
        reset_dut();
        repeat (4) gen_pulse(100, 20, -1);
        repeat (10) tick();
        checks++;
        if (recs.size() !== 3) begin errors++; $display("FAIL basic_count got %0d want 3", recs.size()); end
        for (int i = 0; i < 3; i++) begin
            r = (i < recs.size()) ? recs[i] : '0;
            checks++;
            if (r.period !== 32'd100 || r.width !== 32'd20 || r.ftype !== 2'b00 || r.idx !== 16'(i)) begin
                errors++;
                $display("FAIL basic_rec%0d got p=%0d w=%0d t=%0d i=%0d want p=100 w=20 t=0 i=%0d",
                         i, r.period, r.width, r.ftype, r.idx, i);
            end
        end
    endtask

    task automatic test_frame();
        rec_t r;
        logic [1:0] exp_t [5];
        int         exp_i [5];
        exp_t = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        exp_i = '{0, 1, 2, 0, 1};
        reset_dut();
        frame_type = 2'b10;
        gen_pulse(100, 20, 0);
        gen_pulse(100, 20, -1);
        gen_pulse(100, 20, -1);
        frame_type = 2'b00;
        gen_pulse(100, 20, 0);
        gen_pulse(100, 20, -1);
        gen_pulse(100, 20, -1);
        repeat (5) tick();
        checks++;
        if (recs.size() !== 5) begin errors++; $display("FAIL frame_count got %0d want 5", recs.size()); end
        for (int i = 0; i < 5; i++) begin
            r = (i < recs.size()) ? recs[i] : '0;
            checks++;
            if (r.ftype !== exp_t[i] || r.idx !== 16'(exp_i[i]) || r.period !== 32'd100) begin
                errors++;
                $display("FAIL frame_rec%0d got t=%0d i=%0d p=%0d want t=%0d i=%0d p=100",
                         i, r.ftype, r.idx, r.period, exp_t[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        rec_t r;
        reset_dut();
        meas_ready = 1'b0;
        repeat (4) gen_pulse(100, 20, -1);
        repeat (5) tick();
        checks++;
        if (drop_cnt !== 16'd2) begin errors++; $display("FAIL bp_drop got %0d want 2", drop_cnt); end
        checks++;
        if (meas_valid !== 1'b1 || meas_period !== 32'd100 || meas_width !== 32'd20 || meas_pulse_idx !== 16'd0) begin
            errors++;
            $display("FAIL bp_hold got v=%0b p=%0d w=%0d i=%0d want v=1 p=100 w=20 i=0",
                     meas_valid, meas_period, meas_width, meas_pulse_idx);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL bp_clr got %0d want 0", drop_cnt); end
        // drops coinciding with clear must leave the count at zero
        clr_status = 1'b1;
        repeat (2) gen_pulse(100, 20, -1);
        repeat (3) tick();
        clr_status = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL bp_clr_drop got %0d want 0", drop_cnt); end
        meas_ready = 1'b1;
        tick();
        checks++;
        if (meas_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_valid got %0b want 0", meas_valid); end
        r = (recs.size() > 0) ? recs[0] : '0;
        checks++;
        if (recs.size() !== 1 || r.idx !== 16'd0 || r.period !== 32'd100 || r.width !== 32'd20) begin
            errors++;
            $display("FAIL bp_accept_rec got n=%0d i=%0d p=%0d w=%0d want n=1 i=0 p=100 w=20",
                     recs.size(), r.idx, r.period, r.width);
        end
    endtask

    task automatic test_timeout();
        rec_t r;
        int   n_to;
        int   first_to;
        reset_dut();
        n_to     = 0;
        first_to = -1;
        pulse_in = 1'b1;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (timeout === 1'b1) begin
                n_to++;
                if (first_to < 0) first_to = i;
            end
        end
        checks++;
        if (n_to !== 1) begin errors++; $display("FAIL to_strobes got %0d want 1", n_to); end
        checks++;
        if (first_to !== 1004) begin errors++; $display("FAIL to_cycle got %0d want 1004", first_to); end
        checks++;
        if (recs.size() !== 0 || meas_valid !== 1'b0) begin
            errors++; $display("FAIL to_norec got n=%0d v=%0b want 0 0", recs.size(), meas_valid);
        end
        pulse_in = 1'b0;
        repeat (10) tick();
        repeat (2) gen_pulse(100, 20, -1);
        repeat (5) tick();
        r = (recs.size() > 0) ? recs[0] : '0;
        checks++;
        if (recs.size() !== 1 || r.period !== 32'd100 || r.width !== 32'd20 || r.idx !== 16'd1) begin
            errors++;
            $display("FAIL to_fresh got n=%0d p=%0d w=%0d i=%0d want n=1 p=100 w=20 i=1",
                     recs.size(), r.period, r.width, r.idx);
        end
    endtask

    task automatic test_collision();
        rec_t r;
        logic [1:0] exp_t [3];
        int         exp_i [3];
        exp_t = '{2'b00, 2'b01, 2'b01};
        exp_i = '{0, 0, 1};
        reset_dut();
        frame_type = 2'b01;
        gen_pulse(100, 20, -1);
        gen_pulse(100, 20, 3);
        gen_pulse(100, 20, -1);
        gen_pulse(100, 20, -1);
        repeat (5) tick();
        checks++;
        if (recs.size() !== 3) begin errors++; $display("FAIL coll_count got %0d want 3", recs.size()); end
        for (int i = 0; i < 3; i++) begin
            r = (i < recs.size()) ? recs[i] : '0;
            checks++;
            if (r.ftype !== exp_t[i] || r.idx !== 16'(exp_i[i]) || r.period !== 32'd100 || r.width !== 32'd20) begin
                errors++;
                $display("FAIL coll_rec%0d got t=%0d i=%0d p=%0d w=%0d want t=%0d i=%0d p=100 w=20",
                         i, r.ftype, r.idx, r.period, r.width, exp_t[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        reset_dut();
        meas_ready = 1'b0;
        repeat (2) gen_pulse(100, 20, -1);
        pulse_in = 1'b1;
        repeat (10) tick();
        checks++;
        if (meas_valid !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++; $display("FAIL rmid_pre got v=%0b drop=%0d want 1 1", meas_valid, drop_cnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (meas_valid !== 1'b0 || meas_period !== 32'd0 || meas_width !== 32'd0 ||
            meas_pulse_idx !== 16'd0 || drop_cnt !== 16'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset got v=%0b p=%0d w=%0d i=%0d drop=%0d to=%0b want all 0",
                     meas_valid, meas_period, meas_width, meas_pulse_idx, drop_cnt, timeout);
        end
        rst        = 1'b0;
        meas_ready = 1'b1;
        recs.delete();
        repeat (20) tick();
        pulse_in = 1'b0;
        repeat (30) tick();
        checks++;
        if (recs.size() !== 0 || meas_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_first got n=%0d v=%0b want 0 0", recs.size(), meas_valid);
        end
        gen_pulse(100, 20, -1);
        repeat (5) tick();
        r = (recs.size() > 0) ? recs[0] : '0;
        checks++;
        if (recs.size() !== 1 || r.idx !== 16'd0 || r.ftype !== 2'b00 || r.width !== 32'd20) begin
            errors++;
            $display("FAIL rmid_next got n=%0d i=%0d t=%0d w=%0d want n=1 i=0 t=0 w=20",
                     recs.size(), r.idx, r.ftype, r.width);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_pulse_monitor.md
# timing_pulse_monitor

Capture-side checker for the timing generator outputs. It receives one looped-back timing pulse (CMOS trigger, laser or gate, chosen by board wiring) together with the frame indicators `frame_ext_trig` and `frame_type`. For every pulse it measures period and high width in `clk` cycles, tags the measurement with frame type and pulse index within the frame, and emits one record per pulse over a valid/ready interface toward the register/AXI readout. It sits in the `clk_100m` domain next to the pulse generators.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `pulse_in` (minimum 2).
- `TIMEOUT_CYCLES`, 32'd100_000_000: period counter value that declares the pulse lost.

Ports:
- `clk`  in  1  system clock (`clk_100m`).
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  measurement enable; low forces IDLE and suppresses records.
- `pulse_in`  in  1  asynchronous looped-back pulse, active-high.
- `frame_ext_trig`  in  1  frame trigger, synchronous to `clk`.
- `frame_type`  in  2  01 = A, 10 = B, 00 = background; sampled on the `frame_ext_trig` rising edge.
- `meas_valid`  out  1  record available.
- `meas_ready`  in  1  consumer accepts the record.
- `meas_period`  out  32  cycles between consecutive rising edges.
- `meas_width`  out  32  cycles from rising edge to falling edge.
- `meas_frame_type`  out  2  frame type latched for this pulse.
- `meas_pulse_idx`  out  16  zero-based pulse index within the frame.
- `drop_cnt`  out  16  records lost to backpressure; saturating.
- `timeout`  out  1  one-cycle strobe when `TIMEOUT_CYCLES` is reached.
- `clr_status`  in  1  clears `drop_cnt`.

## Operation
- `pulse_in` passes through `SYNC_STAGES` flops and one edge register, which produces `rise` and `fall` strobes.
- FSM states:
  - IDLE: waits for `rise`, then goes to HIGH. Period and width counters are loaded with 1. No record is produced.
  - HIGH: both counters increment. On `fall`, the width is frozen and the FSM goes to LOW.
  - LOW: the period counter increments. On `rise`, the FSM emits a record {period, frozen width, tag of the completed pulse}, reloads the counters with 1, and returns to HIGH.
  - `rise` while in HIGH cannot occur, because the edge register enforces alternation.
- Period and width are exact cycle counts between detected edges. Example: rises at cycles 0 and 100 give period = 100.
- Timeout: the period counter reaching `TIMEOUT_CYCLES` in HIGH or LOW produces a `timeout` strobe and a move to IDLE. No record is produced. Counters saturate and never wrap.
- Frame handling:
  - On the `frame_ext_trig` rising edge, `frame_type` is latched and the pulse index is reset.
  - The next detected `rise` gets index 0. Each following `rise` increments the index, saturating at 0xFFFF.
  - Each pulse carries the tag {frame_type, idx} captured at its own `rise`.
- Simultaneous frame edge and `rise`: the emitted record keeps the old tag, and the new pulse gets the new frame type with index 0.
- Output buffer is one entry deep:
  - A record is written when the buffer is empty, or when `meas_valid & meas_ready` in the same cycle.
  - Otherwise the new record is dropped, the buffered record stays, and `drop_cnt` increments.
  - `clr_status` and a drop in the same cycle leave `drop_cnt` = 0.
- `enable` low: the FSM moves to IDLE, the frame tag is held, and a pending record stays valid until accepted.

## Timing
- Reset values: `meas_valid`=0, all `meas_*` data=0, `drop_cnt`=0, `timeout`=0, FSM=IDLE, index=0, latched frame type=00, synchronizer flops=0.
- Pulse edge to `rise`/`fall` strobe: `SYNC_STAGES`+1 cycles.
- `rise` to `meas_valid`: 1 cycle.
- `meas_*` data is stable while `meas_valid` is high and `meas_ready` is low.
- `rst` in mid-pulse discards everything. After release, the first `rise` only starts a measurement.
- Minimum measurable width or low time is 1 cycle; pulses shorter than that may be missed.

## Structure
- Package `timing_mon_pkg`:
  - FSM state enum {IDLE, HIGH, LOW}.
  - `FRAME_A`=2'b01, `FRAME_B`=2'b10, `FRAME_BG`=2'b00.
  - Count width 32 and index width 16 constants.
- Sub-module `pulse_sync_edge`: synchronizer plus edge detector, parameterized by `SYNC_STAGES`, with outputs `level`, `rise` and `fall`.

## Test plan
- Pulses with period 100 and high 20, `meas_ready`=1: records show period 100, width 20 from the second rise onward, index 0,1,2…
- `frame_ext_trig` pulse with `frame_type`=10 before a pulse burst, then type 00: the index restarts at 0 and `meas_frame_type` goes 10 → 00 at the correct pulse.
- `meas_ready`=0 across 3 records: the first record is held unchanged and `drop_cnt`=2. Asserting `clr_status` then gives `drop_cnt`=0.
- `pulse_in` stuck high and `TIMEOUT_CYCLES`=1000: `timeout` strobes once at count 1000, the FSM is in IDLE, no record is produced, and the next rise starts a fresh measurement.
- Frame edge and `rise` in the same cycle: the record carries the old tag, and the next record shows index 0 with the new type.
- `rst` asserted during HIGH: all outputs at reset values on the following cycle, and the first post-reset rise emits nothing.
